ram_stream_reader: RTL and testbench
====================================

Name: ram_stream_reader

Overview:
- DMA-style read engine placed directly upstream of the single-port image RAM; it drives the RAM address and consumes the RAM read data.
- On START it fetches LEN consecutive words from BASE and emits them as a valid/ready stream to the processing/display pipeline.
- It asserts OUT_LAST on the final beat and pulses DONE when the final beat is accepted.
- The RAM read is combinational: MEM_RD is valid in the same cycle that MEM_ADDR is presented.

Parameters:
- WIDTH, 32, data and address width; matches the RAM.
- DEPTH, 2001, number of RAM words; addresses run 0..DEPTH-1.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request; ignored while BUSY=1.
- BASE  in  WIDTH  first word address; sampled at START.
- LEN  in  WIDTH  word count; sampled at START.
- BUSY  out  1  high from the edge after START until the edge that raises DONE.
- DONE  out  1  one-cycle pulse at the end of a transfer.
- MEM_ADDR  out  WIDTH  RAM address.
- MEM_WE  out  1  RAM write enable; tied 0.
- MEM_RD  in  WIDTH  RAM read data, combinational.
- OUT_DATA  out  WIDTH  stream data, registered.
- OUT_VALID  out  1  stream valid.
- OUT_READY  in  1  downstream ready.
- OUT_LAST  out  1  marks the final beat; qualified by OUT_VALID.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - state=IDLE; BUSY, DONE, OUT_VALID, OUT_LAST, OUT_DATA, MEM_ADDR = 0.
  - The transfer in progress is abandoned; there is no resume.
- States: IDLE, STREAM, FINISH.
- IDLE:
  - On START: latch BASE into the address register and LEN into the remaining counter.
  - If LEN=0 or BASE>=DEPTH, go to FINISH and emit no beats.
  - Otherwise go to STREAM.
  - MEM_ADDR holds its last value while in IDLE.
- STREAM:
  - MEM_ADDR = address register.
  - Load condition: remaining>0 and (OUT_VALID=0 or OUT_READY=1).
  - On load: OUT_DATA<=MEM_RD, OUT_VALID<=1, OUT_LAST<=(remaining==1), address<=next, remaining<=remaining-1.
  - If OUT_VALID=1, OUT_READY=1 and remaining=0, OUT_VALID<=0.
  - When the beat with OUT_LAST=1 completes a handshake, go to FINISH.
- FINISH: DONE=1 for exactly one cycle, BUSY<=0, then IDLE.
- Latency and throughput:
  - START sampled at edge k; first beat valid after edge k+1.
  - With OUT_READY held at 1, one beat per cycle; an N-word transfer has DONE high during cycle k+N+1.
- Handshake rules:
  - While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_LAST are held stable and MEM_ADDR does not advance.
  - OUT_VALID never drops without a handshake.
- Address wrap: next = (addr==DEPTH-1) ? 0 : addr+1.
- Simultaneous events: a START arriving in the same cycle as DONE is ignored; a new START is accepted only in IDLE.
- LEN is treated as unsigned and is not clipped to DEPTH; long transfers wrap repeatedly.

Optional Feature:
- Macro: RAM_STREAM_BYTE_UNPACK_EN.
- Defined:
  - Each fetched word yields 4 beats, byte order bits[7:0], [15:8], [23:16], [31:24].
  - OUT_DATA = zero-extended byte.
  - A 2-bit byte counter is used; RAM is read once per word, and the word is held in an internal register.
  - MEM_ADDR advances only after byte 3 is accepted.
  - OUT_LAST is asserted on byte 3 of the last word.
  - Throughput is 1 byte per cycle; LEN still counts words.
- Undefined: whole-word beats as described under Behaviour; no byte counter is instantiated.

Decomposition:
- Package ram_stream_pkg:
  - state enum (IDLE, STREAM, FINISH).
  - DEFAULT_DEPTH=2001.
  - BYTES_PER_WORD=4.
- Sub-module ram_addr_gen:
  - Holds the address register and the wrapping increment at DEPTH.
  - Inputs: load, base, advance. Output: addr.

Test Plan:
- BASE=10, LEN=4, RAM[10..13]=A..D, OUT_READY=1 -> beats A,B,C,D on consecutive cycles; OUT_LAST only on D; DONE one cycle after D; BUSY high for 5 cycles.
- Same transfer with OUT_READY toggling 1,0,0,1,... -> no beat lost or duplicated; OUT_DATA stable while stalled; MEM_ADDR frozen during the stall.
- LEN=0, and separately BASE=2001 -> no OUT_VALID; DONE pulses at edge k+1.
- BASE=1999, LEN=4 -> addresses 1999, 2000, 0, 1 and the data in that order.
- RST_N asserted after the 2nd beat of an 8-word transfer -> all outputs 0 immediately; a new START with BASE=0, LEN=2 completes normally.
- With RAM_STREAM_BYTE_UNPACK_EN: BASE=0, LEN=2, RAM[0]=0x44332211, RAM[1]=0x88776655 -> beats 0x11..0x88, 8 beats; OUT_LAST on 0x88.

Source files
------------

// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg: shared state type and constants for the RAM stream reader.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StFinish
    } state_e;

    localparam int unsigned DEFAULT_DEPTH  = 2001;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/ram_addr_gen.sv
// ram_addr_gen: RAM address register with a wrapping increment at DEPTH.
module ram_addr_gen
    import ram_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic [WIDTH-1:0] base,
    input  logic             advance,
    output logic [WIDTH-1:0] addr
);

    localparam logic [WIDTH-1:0] LastAddr = WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0] addr_q;

    // Load takes priority over advance; advancing past the top word returns to 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_q <= '0;
        end else if (load) begin
            addr_q <= base;
        end else if (advance) begin
            addr_q <= (addr_q == LastAddr) ? '0 : addr_q + WIDTH'(1);
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: fetches LEN words from BASE of a combinational-read RAM and
// emits them as a valid/ready stream with OUT_LAST and a DONE pulse.
// Optional build macro RAM_STREAM_BYTE_UNPACK_EN splits each word into four
// zero-extended byte beats, least significant byte first.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] BASE,
    input  logic [WIDTH-1:0] LEN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] MEM_ADDR,
    output logic             MEM_WE,
    input  logic [WIDTH-1:0] MEM_RD,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_LAST
);

    localparam logic [WIDTH-1:0] DepthW = WIDTH'(DEPTH);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             busy_q, busy_d;
    logic             addr_load, addr_advance;
    logic             degenerate, load_beat, handshake;
    logic [WIDTH-1:0] addr;

    assign degenerate = (LEN == '0) || (BASE >= DepthW);
    assign handshake  = out_valid_q && OUT_READY;
    assign load_beat  = (state_q == StStream) && (remaining_q != '0) &&
                        (!out_valid_q || OUT_READY);
    assign addr_load  = (state_q == StIdle) && START;

`ifdef RAM_STREAM_BYTE_UNPACK_EN
    localparam logic [1:0] LastByte = 2'(BYTES_PER_WORD - 1);

    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [7:0]       byte_sel;
    logic             last_byte;

    assign last_byte    = (byte_cnt_q == LastByte);
    // Byte 0 comes straight off the RAM; the rest come from the captured word.
    assign byte_sel     = (byte_cnt_q == 2'd0) ? MEM_RD[7:0]
                                               : word_q[{byte_cnt_q, 3'b000} +: 8];
    // The next word is only presented once the current one is fully emitted.
    assign addr_advance = load_beat && last_byte;
`else
    assign addr_advance = load_beat;
`endif

    ram_addr_gen #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_addr_gen (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .load   (addr_load),
        .base   (BASE),
        .advance(addr_advance),
        .addr   (addr)
    );

    // Next-state, word bookkeeping and stream register updates.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
`ifdef RAM_STREAM_BYTE_UNPACK_EN
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    busy_d      = 1'b1;
                    state_d     = StStream;
                    // Empty or out-of-range requests spend one empty STREAM cycle,
                    // so DONE always lands N+1 cycles after the START edge.
                    remaining_d = degenerate ? '0 : LEN;
`ifdef RAM_STREAM_BYTE_UNPACK_EN
                    byte_cnt_d  = '0;
`endif
                end
            end
            StStream: begin
                if (load_beat) begin
                    out_valid_d = 1'b1;
`ifdef RAM_STREAM_BYTE_UNPACK_EN
                    out_data_d  = {{(WIDTH-8){1'b0}}, byte_sel};
                    out_last_d  = last_byte && (remaining_q == One);
                    byte_cnt_d  = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd0) begin
                        word_d = MEM_RD;
                    end
                    if (last_byte) begin
                        remaining_d = remaining_q - One;
                    end
`else
                    out_data_d  = MEM_RD;
                    out_last_d  = (remaining_q == One);
                    remaining_d = remaining_q - One;
`endif
                end else if (handshake) begin
                    // Nothing left to fetch: the final beat has been taken.
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if ((handshake && out_last_q) || ((remaining_q == '0) && !out_valid_q)) begin
                    state_d = StFinish;
                    busy_d  = 1'b0;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state and registered stream outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

`ifdef RAM_STREAM_BYTE_UNPACK_EN
    // Byte position within the current word and the captured word itself.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end
`endif

    assign BUSY      = busy_q;
    assign DONE      = (state_q == StFinish);
    assign MEM_ADDR  = addr;
    assign MEM_WE    = 1'b0;
    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_LAST  = out_last_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: randomized self-checking bench for ram_stream_reader.
module tb_ram_stream_reader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2001;
`ifdef RAM_STREAM_BYTE_UNPACK_EN
    localparam int BPW = 4;
`else
    localparam int BPW = 1;
`endif

    logic        CLK, RST_N, START, OUT_READY;
    logic        BUSY, DONE, MEM_WE, OUT_VALID, OUT_LAST;
    logic [31:0] BASE, LEN, MEM_ADDR, MEM_RD, OUT_DATA;

    logic [31:0] ram [0:DEPTH-1];

    int checks   = 0;
    int failures = 0;

    // Observations from the most recent transfer.
    logic [31:0] exp_q[$];
    logic [31:0] got_data[$];
    logic        got_last[$];
    logic [31:0] st_d0[$], st_d1[$], st_a0[$], st_a1[$];
    logic        st_l0[$], st_l1[$], st_v1[$];
    int          done_c, busy_cnt, first_c;
    logic [31:0] addr0;
    logic        done_after, busy_after;

    ram_stream_reader #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .BASE     (BASE),
        .LEN      (LEN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .MEM_ADDR (MEM_ADDR),
        .MEM_WE   (MEM_WE),
        .MEM_RD   (MEM_RD),
        .OUT_DATA (OUT_DATA),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_LAST (OUT_LAST)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    assign MEM_RD = (MEM_ADDR < 32'(DEPTH)) ? ram[MEM_ADDR[10:0]] : 32'hDEAD_BEEF;

    // Reference: the beat sequence a request should produce, from the RAM image.
    function automatic void build_expected(input int base, input int len);
        exp_q.delete();
        if (len == 0 || base >= DEPTH) return;
        for (int i = 0; i < len; i++) begin
            int          a  = (base + i) % DEPTH;
            logic [10:0] ai = 11'(a);
            for (int b = 0; b < BPW; b++) begin
                if (BPW == 1) exp_q.push_back(ram[ai]);
                else          exp_q.push_back((ram[ai] >> (8 * b)) & 32'hFF);
            end
        end
    endfunction

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    // Issue one request and record what the stream did; no judgement here.
    task automatic do_transfer(input int base, input int len, input int mode, input bit poke);
        bit stalled = 1'b0;
        got_data.delete(); got_last.delete();
        st_d0.delete(); st_d1.delete(); st_a0.delete(); st_a1.delete();
        st_l0.delete(); st_l1.delete(); st_v1.delete();
        done_c = -1; first_c = -1; busy_cnt = 0;
        START = 1'b1; BASE = 32'(base); LEN = 32'(len); OUT_READY = 1'b1;
        @(posedge CLK); #1;
        START = poke;
        addr0 = MEM_ADDR;
        for (int c = 0; c < 400; c++) begin
            if (poke) begin
                BASE = $urandom_range(0, DEPTH - 1);
                LEN  = $urandom_range(1, 5);
            end
            if (stalled) begin
                st_d1.push_back(OUT_DATA); st_l1.push_back(OUT_LAST);
                st_a1.push_back(MEM_ADDR); st_v1.push_back(OUT_VALID);
            end
            if (BUSY) busy_cnt++;
            if (DONE) begin
                done_c = c;
                break;
            end
            OUT_READY = ready_for(mode, c);
            stalled   = 1'b0;
            if (OUT_VALID) begin
                if (first_c < 0) first_c = c;
                if (OUT_READY) begin
                    got_data.push_back(OUT_DATA);
                    got_last.push_back(OUT_LAST);
                end else begin
                    stalled = 1'b1;
                    st_d0.push_back(OUT_DATA); st_l0.push_back(OUT_LAST);
                    st_a0.push_back(MEM_ADDR);
                end
            end
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
        START      = 1'b0;
        done_after = DONE;
        busy_after = BUSY;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({BUSY, DONE, OUT_VALID, OUT_LAST, MEM_WE} !== 5'b0 || OUT_DATA !== 32'd0 ||
            MEM_ADDR !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs got flags=%b data=%h addr=%h want all zero",
                     {BUSY, DONE, OUT_VALID, OUT_LAST, MEM_WE}, OUT_DATA, MEM_ADDR);
        end
        RST_N = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if ({BUSY, DONE, OUT_VALID} !== 3'b0) begin
            failures++;
            $display("FAIL reset_idle got busy/done/valid=%b want 000", {BUSY, DONE, OUT_VALID});
        end
    endtask

    task automatic test_basic;
        for (int i = 0; i < 4; i++) ram[10 + i] = 32'hA0A0_0000 + 32'(i);
        build_expected(10, 4);
        do_transfer(10, 4, 0, 1'b0);
        checks++;
        if (addr0 !== 32'd10) begin
            failures++; $display("FAIL basic_addr got %0d want 10", addr0);
        end
        checks++;
        if (got_data.size() != exp_q.size()) begin
            failures++;
            $display("FAIL basic_count got %0d want %0d", got_data.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_data.size()) begin
            checks++;
            if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
                failures++;
                $display("FAIL basic_beat%0d got %h/last=%b want %h/last=%b", i, got_data[i],
                         got_last[i], exp_q[i], (i == exp_q.size() - 1));
            end
        end
        checks++;
        if (first_c != 1) begin
            failures++; $display("FAIL basic_first got %0d want 1", first_c);
        end
        checks++;
        if (done_c != exp_q.size() + 1 || done_after !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got cycle %0d after=%b want %0d after=0", done_c,
                     done_after, exp_q.size() + 1);
        end
        checks++;
        if (busy_cnt != exp_q.size() + 1) begin
            failures++;
            $display("FAIL basic_busy got %0d want %0d", busy_cnt, exp_q.size() + 1);
        end
    endtask

    task automatic test_stall;
        build_expected(10, 4);
        do_transfer(10, 4, 1, 1'b0);
        checks++;
        if (got_data.size() != exp_q.size() || done_c < 0) begin
            failures++;
            $display("FAIL stall_count got %0d done=%0d want %0d", got_data.size(), done_c,
                     exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_data.size()) begin
            checks++;
            if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
                failures++;
                $display("FAIL stall_beat%0d got %h want %h", i, got_data[i], exp_q[i]);
            end
        end
        foreach (st_d1[i]) begin
            checks++;
            if (st_v1[i] !== 1'b1 || st_d1[i] !== st_d0[i] || st_l1[i] !== st_l0[i] ||
                st_a1[i] !== st_a0[i]) begin
                failures++;
                $display("FAIL stall_hold%0d got v=%b d=%h a=%h want v=1 d=%h a=%h", i,
                         st_v1[i], st_d1[i], st_a1[i], st_d0[i], st_a0[i]);
            end
        end
    endtask

    task automatic test_degenerate;
        int bases[2];
        int lens[2];
        bases[0] = 5;    lens[0] = 0;
        bases[1] = 2001; lens[1] = 3;
        for (int t = 0; t < 2; t++) begin
            do_transfer(bases[t], lens[t], 0, 1'b0);
            checks++;
            if (got_data.size() != 0 || first_c != -1) begin
                failures++;
                $display("FAIL degen%0d_beats got %0d first=%0d want none", t, got_data.size(),
                         first_c);
            end
            checks++;
            if (done_c != 1 || busy_cnt != 1 || done_after !== 1'b0) begin
                failures++;
                $display("FAIL degen%0d_done got cycle %0d busy=%0d want cycle 1 busy=1", t,
                         done_c, busy_cnt);
            end
        end
    endtask

    task automatic test_wrap;
        build_expected(1999, 4);
        do_transfer(1999, 4, 0, 1'b0);
        checks++;
        if (got_data.size() != exp_q.size()) begin
            failures++;
            $display("FAIL wrap_count got %0d want %0d", got_data.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_data.size()) begin
            checks++;
            if (got_data[i] !== exp_q[i]) begin
                failures++; $display("FAIL wrap_beat%0d got %h want %h", i, got_data[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midtransfer;
        START = 1'b1; BASE = 32'd100; LEN = 32'd8; OUT_READY = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({BUSY, DONE, OUT_VALID, OUT_LAST} !== 4'b0 || OUT_DATA !== 32'd0 ||
            MEM_ADDR !== 32'd0) begin
            failures++;
            $display("FAIL midreset_outputs got flags=%b data=%h addr=%h want zero",
                     {BUSY, DONE, OUT_VALID, OUT_LAST}, OUT_DATA, MEM_ADDR);
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        build_expected(0, 2);
        do_transfer(0, 2, 0, 1'b0);
        checks++;
        if (got_data.size() != exp_q.size() || done_c != exp_q.size() + 1) begin
            failures++;
            $display("FAIL midreset_after got %0d beats done=%0d want %0d done=%0d",
                     got_data.size(), done_c, exp_q.size(), exp_q.size() + 1);
        end
        foreach (exp_q[i]) if (i < got_data.size()) begin
            checks++;
            if (got_data[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL midreset_beat%0d got %h want %h", i, got_data[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int bases[2];
        int lens[2];
        bases[0] = 300; lens[0] = 3;
        bases[1] = 50;  lens[1] = 2;
        for (int t = 0; t < 2; t++) begin
            build_expected(bases[t], lens[t]);
            do_transfer(bases[t], lens[t], 0, t == 0);
            checks++;
            if (got_data.size() != exp_q.size() || busy_after !== 1'b0 || done_after !== 1'b0) begin
                failures++;
                $display("FAIL b2b%0d got %0d beats busy_after=%b done_after=%b want %0d 0 0", t,
                         got_data.size(), busy_after, done_after, exp_q.size());
            end
            foreach (exp_q[i]) if (i < got_data.size()) begin
                checks++;
                if (got_data[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL b2b%0d_beat%0d got %h want %h", t, i, got_data[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 8; t++) begin
            int base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1995, 2000))
                                                   : int'($urandom_range(0, 2000));
            int len  = $urandom_range(1, 7);
            build_expected(base, len);
            do_transfer(base, len, 2, 1'b0);
            checks++;
            if (got_data.size() != exp_q.size() || done_c < 0 || busy_cnt != done_c) begin
                failures++;
                $display("FAIL rand%0d base=%0d len=%0d got %0d beats done=%0d busy=%0d want %0d",
                         t, base, len, got_data.size(), done_c, busy_cnt, exp_q.size());
            end
            foreach (exp_q[i]) if (i < got_data.size()) begin
                checks++;
                if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
                    failures++;
                    $display("FAIL rand%0d_beat%0d got %h/%b want %h/%b", t, i, got_data[i],
                             got_last[i], exp_q[i], (i == exp_q.size() - 1));
                end
            end
            foreach (st_d1[i]) begin
                checks++;
                if (st_v1[i] !== 1'b1 || st_d1[i] !== st_d0[i] || st_a1[i] !== st_a0[i]) begin
                    failures++;
                    $display("FAIL rand%0d_hold%0d got v=%b d=%h want v=1 d=%h", t, i, st_v1[i],
                             st_d1[i], st_d0[i]);
                end
            end
        end
    endtask

`ifdef RAM_STREAM_BYTE_UNPACK_EN
    task automatic test_byte_unpack;
        ram[0] = 32'h4433_2211;
        ram[1] = 32'h8877_6655;
        do_transfer(0, 2, 0, 1'b0);
        checks++;
        if (got_data.size() != 8) begin
            failures++; $display("FAIL bytes_count got %0d want 8", got_data.size());
        end
        for (int i = 0; i < 8; i++) if (i < got_data.size()) begin
            checks++;
            if (got_data[i] !== 32'((i + 1) * 17) || got_last[i] !== (i == 7)) begin
                failures++;
                $display("FAIL bytes_beat%0d got %h/%b want %h/%b", i, got_data[i], got_last[i],
                         32'((i + 1) * 17), (i == 7));
            end
        end
    endtask
`endif

    initial begin
        RST_N = 1'b0; START = 1'b0; BASE = '0; LEN = '0; OUT_READY = 1'b0;
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
        test_reset();
        test_basic();
        test_stall();
        test_degenerate();
        test_wrap();
        test_reset_midtransfer();
        test_back_to_back();
        test_random();
`ifdef RAM_STREAM_BYTE_UNPACK_EN
        test_byte_unpack();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
